// File: rtl/ddr_app_responder_pkg.sv
// Shared constants for the DDR app-interface responder: command encodings,
// throttle LFSR seed/taps and the LFSR step function.
package ddr_app_responder_pkg;

   localparam logic [2:0]  CMD_WRITE = 3'b000;
   localparam logic [2:0]  CMD_READ  = 3'b001;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Taps 16,14,13,11 expressed as zero-based bit positions.
   localparam int LFSR_TAP_A = 15;
   localparam int LFSR_TAP_B = 13;
   localparam int LFSR_TAP_C = 12;
   localparam int LFSR_TAP_D = 10;

   // One step of the 16-bit Fibonacci LFSR: shift left, feedback into bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D];
      return {s[14:0], fb};
   endfunction

endpackage

// File: rtl/ddr_app_responder_fifo.sv
// Small synchronous first-word-fall-through FIFO used for the pending write
// addresses and the pending write beats. Push while full and pop while empty
// are ignored, so callers may drive push/pop without pre-qualifying them.
module ddr_model_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      store_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
   logic                  do_push, do_pop;

   assign full_o  = (cnt_q == CNT_FULL);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = store_q[rd_ptr_q];

   // Next-state for pointers and occupancy; push and pop in one cycle leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Entry storage; contents need no reset because occupancy guards every read.
   always_ff @(posedge clk_i) begin
      if (do_push) store_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/ddr_app_responder.sv
// Memory-side stand-in for the DDR user (app_*) interface. Commands and write
// beats are queued separately and paired in order into an on-chip RAM; reads
// wait until all earlier writes have retired, then return after a fixed
// latency through a shift pipe. A calibration delay and an optional LFSR
// ready-throttle mimic the behaviour of the real memory-interface IP.
//
// Handshakes: a command transfers on a rising edge where app_en & app_rdy; a
// write beat transfers where app_wdf_wren & app_wdf_rdy. app_rdy depends
// combinationally on app_cmd. app_rd_data_valid is a one-cycle pulse with no
// back-pressure, one per accepted read, in command order.
module ddr_app_responder
   import ddr_app_responder_pkg::*;
#(
   parameter int DDR_DATA_WIDTH  = 128,
   parameter int DDR_ADDR_WIDTH  = 28,
   parameter int MEM_DEPTH_LOG2  = 10,
   parameter int RD_LATENCY      = 8,
   parameter int CALIB_CYCLES    = 64,
   parameter int FIFO_DEPTH_LOG2 = 3,
   parameter int RDY_THROTTLE    = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
   input  logic [2:0]                  app_cmd,
   input  logic                        app_en,
   output logic                        app_rdy,
   input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
   input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                        app_wdf_wren,
   input  logic                        app_wdf_end,
   output logic                        app_wdf_rdy,
   output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
   output logic                        app_rd_data_valid,
   output logic                        init_calib_complete,
   output logic [15:0]                 rd_cmd_cnt,
   output logic [15:0]                 wr_cmd_cnt,
   output logic                        err_flag
);

   localparam int          DW         = DDR_DATA_WIDTH;
   localparam int          MASK_W     = DDR_DATA_WIDTH / 8;
   localparam int          MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
   localparam int          PIPE_LEN   = RD_LATENCY - 1;
   localparam int          WD_W       = DW + MASK_W;
   localparam logic [15:0] CALIB_LAST = 16'(CALIB_CYCLES - 1);

   // ---------------- calibration and throttle ----------------
   logic [15:0] calib_cnt_q, calib_cnt_d;
   logic        calib_q, calib_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        cmd_ok, wdf_ok;

   // Count up to the last calibration cycle, then latch calibration done for good.
   always_comb begin
      calib_cnt_d = calib_cnt_q;
      calib_d     = calib_q;
      if (!calib_q) begin
         if (calib_cnt_q == CALIB_LAST) calib_d = 1'b1;
         else                           calib_cnt_d = calib_cnt_q + 16'd1;
      end
   end

   // The throttle LFSR only runs once calibration is done.
   always_comb begin
      lfsr_d = lfsr_q;
      if (calib_q) lfsr_d = lfsr_next(lfsr_q);
   end

   // Calibration counter, done flag and LFSR registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         calib_cnt_q <= '0;
         calib_q     <= 1'b0;
         lfsr_q      <= LFSR_SEED;
      end else begin
         calib_cnt_q <= calib_cnt_d;
         calib_q     <= calib_d;
         lfsr_q      <= lfsr_d;
      end
   end

   assign cmd_ok = (RDY_THROTTLE == 0) | lfsr_q[0] | lfsr_q[1];
   assign wdf_ok = (RDY_THROTTLE == 0) | lfsr_q[2] | lfsr_q[3];

   // ---------------- write queues ----------------
   logic                      waddr_full, waddr_empty;
   logic                      wdata_full, wdata_empty;
   logic [MEM_DEPTH_LOG2-1:0] waddr_head;
   logic [WD_W-1:0]           wdata_head;
   logic [DW-1:0]             wd_data;
   logic [MASK_W-1:0]         wd_mask;
   logic [MEM_DEPTH_LOG2-1:0] cmd_idx;
   logic                      is_read, is_write, is_illegal;
   logic                      cmd_acc, rd_acc, wr_acc, ill_acc, wdf_acc;
   logic                      retire;

   assign is_read    = (app_cmd == CMD_READ);
   assign is_write   = (app_cmd == CMD_WRITE);
   assign is_illegal = !is_read && !is_write;

   // A read may only be taken once every earlier write command has retired.
   assign app_rdy     = calib_q & cmd_ok & ~waddr_full & ~(is_read & ~waddr_empty);
   assign app_wdf_rdy = calib_q & wdf_ok & ~wdata_full;

   assign cmd_acc = app_en & app_rdy;
   assign rd_acc  = cmd_acc & is_read;
   assign wr_acc  = cmd_acc & is_write;
   assign ill_acc = cmd_acc & is_illegal;
   assign wdf_acc = app_wdf_wren & app_wdf_rdy;

   // Beat index: addr[2:0] are within-beat, bits above the RAM depth alias.
   assign cmd_idx = app_addr[MEM_DEPTH_LOG2+2:3];

   // Pair the oldest command with the oldest beat as soon as both exist.
   assign retire  = ~waddr_empty & ~wdata_empty & ~rst;
   assign wd_data = wdata_head[DW-1:0];
   assign wd_mask = wdata_head[WD_W-1:DW];

   ddr_model_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
      .WIDTH      (MEM_DEPTH_LOG2)
   ) u_waddr_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (wr_acc),
      .data_i  (cmd_idx),
      .pop_i   (retire),
      .data_o  (waddr_head),
      .full_o  (waddr_full),
      .empty_o (waddr_empty)
   );

   ddr_model_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
      .WIDTH      (WD_W)
   ) u_wdata_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (wdf_acc),
      .data_i  ({app_wdf_mask, app_wdf_data}),
      .pop_i   (retire),
      .data_o  (wdata_head),
      .full_o  (wdata_full),
      .empty_o (wdata_empty)
   );

   // ---------------- RAM ----------------
   logic [DW-1:0] mem_q [MEM_DEPTH];

   // Byte-masked write of a retiring beat; a set mask bit keeps the old byte.
   always_ff @(posedge clk) begin
      if (retire) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (!wd_mask[b]) mem_q[waddr_head][b*8 +: 8] <= wd_data[b*8 +: 8];
         end
      end
   end

   // ---------------- read pipe ----------------
   logic [DW-1:0]       pipe_dat_q [PIPE_LEN];
   logic [PIPE_LEN-1:0] pipe_vld_q;
   logic [DW-1:0]       rd_data_q;
   logic                rd_vld_q;

   // Stage 0 samples the RAM at the accept edge (old data on a same-edge write);
   // the output stage only loads on a valid beat so app_rd_data holds between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PIPE_LEN; k++) pipe_dat_q[k] <= '0;
         pipe_vld_q <= '0;
         rd_data_q  <= '0;
         rd_vld_q   <= 1'b0;
      end else begin
         pipe_dat_q[0] <= mem_q[cmd_idx];
         pipe_vld_q[0] <= rd_acc;
         for (int k = 1; k < PIPE_LEN; k++) begin
            pipe_dat_q[k] <= pipe_dat_q[k-1];
            pipe_vld_q[k] <= pipe_vld_q[k-1];
         end
         rd_vld_q <= pipe_vld_q[PIPE_LEN-1];
         if (pipe_vld_q[PIPE_LEN-1]) rd_data_q <= pipe_dat_q[PIPE_LEN-1];
      end
   end

   // ---------------- counters and error ----------------
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic        err_q, err_d;

   // Accepted-command counters wrap naturally; the error flag is sticky.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      err_d    = err_q;
      if (rd_acc) rd_cnt_d = rd_cnt_q + 16'd1;
      if (wr_acc) wr_cnt_d = wr_cnt_q + 16'd1;
      if (ill_acc || (wdf_acc && !app_wdf_end)) err_d = 1'b1;
   end

   // Counter and error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         err_q    <= err_d;
      end
   end

   assign app_rd_data         = rd_data_q;
   assign app_rd_data_valid   = rd_vld_q;
   assign init_calib_complete = calib_q;
   assign rd_cmd_cnt          = rd_cnt_q;
   assign wr_cmd_cnt          = wr_cnt_q;
   assign err_flag            = err_q;

endmodule

// File: tb/tb_ddr_app_responder.sv
// Bench for ddr_app_responder in throttled-ready mode. Drivers push the expected
// read beat and its accept edge into queues; a negedge monitor pops and checks
// data and latency whenever app_rd_data_valid is seen.
module tb_ddr_app_responder;
   import ddr_app_responder_pkg::*;

   localparam int DW = 128;
   localparam int AW = 28;
   localparam int MW = DW / 8;
   localparam int RL = 8;
   localparam int CC = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy;
   logic [DW-1:0] app_wdf_data;
   logic [MW-1:0] app_wdf_mask;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic          app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;
   logic          init_calib_complete;
   logic [15:0]   rd_cmd_cnt;
   logic [15:0]   wr_cmd_cnt;
   logic          err_flag;

   ddr_app_responder #(
      .DDR_DATA_WIDTH  (DW),
      .DDR_ADDR_WIDTH  (AW),
      .MEM_DEPTH_LOG2  (10),
      .RD_LATENCY      (RL),
      .CALIB_CYCLES    (CC),
      .FIFO_DEPTH_LOG2 (3),
      .RDY_THROTTLE    (1)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .init_calib_complete (init_calib_complete),
      .rd_cmd_cnt          (rd_cmd_cnt),
      .wr_cmd_cnt          (wr_cmd_cnt),
      .err_flag            (err_flag)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] exp_q[$];
   int unsigned   acc_q[$];
   logic [DW-1:0] mon_e;
   int unsigned   mon_a;

   logic [DW-1:0] ref_mem [16];
   bit            ref_vld [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Every valid pulse must match the oldest outstanding read in data and latency.
   always @(negedge clk) begin
      if (app_rd_data_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: valid pulse with data %h, required no pulse", app_rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            mon_a = acc_q.pop_front();
            if (app_rd_data !== mon_e) begin
               n_fail++;
               $display("FAIL rd_data: got %h, required %h", app_rd_data, mon_e);
            end
            n_checks++;
            if (cyc + 1 - mon_a != RL) begin
               n_fail++;
               $display("FAIL rd_latency: got %0d, required %0d", cyc + 1 - mon_a, RL);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic issue_cmd(input logic [2:0] c, input logic [AW-1:0] a,
                            input logic [DW-1:0] e, input string name);
      bit ok = 1'b0;
      app_cmd  = c;
      app_addr = a;
      app_en   = 1'b1;
      for (int t = 0; t < 300 && !ok; t++) begin
         #1;
         if (app_rdy) begin
            ok = 1'b1;
            if (c == CMD_READ) begin
               exp_q.push_back(e);
               acc_q.push_back(cyc + 1);
            end
         end
         @(negedge clk);
      end
      app_en = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: app_rdy %b, required 1 within 300 cycles", name, app_rdy);
      end
   endtask

   task automatic send_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m,
                           input logic last, input string name);
      bit ok = 1'b0;
      app_wdf_data = d;
      app_wdf_mask = m;
      app_wdf_end  = last;
      app_wdf_wren = 1'b1;
      for (int t = 0; t < 300 && !ok; t++) begin
         #1;
         if (app_wdf_rdy) ok = 1'b1;
         @(negedge clk);
      end
      app_wdf_wren = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: app_wdf_rdy %b, required 1 within 300 cycles", name, app_wdf_rdy);
      end
   endtask

   task automatic do_reset(input string name);
      int          rise = -1;
      bit          rdy_bad = 1'b0;
      int unsigned base;
      rst          = 1'b1;
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      app_cmd      = CMD_READ;
      @(negedge clk);
      exp_q.delete();
      acc_q.delete();
      rst  = 1'b0;
      base = cyc;
      #1;
      check({name, "_reset_outs"},
            {rd_cmd_cnt, wr_cmd_cnt, err_flag, app_rd_data_valid, init_calib_complete, |app_rd_data},
            64'd0);
      for (int t = 0; t < 200 && rise < 0; t++) begin
         @(negedge clk);
         #1;
         if (init_calib_complete) rise = int'(cyc - base);
         else if (app_rdy || app_wdf_rdy) rdy_bad = 1'b1;
      end
      check({name, "_calib_cycle"}, 64'(rise), 64'(CC));
      check({name, "_rdy_before_calib"}, 64'(rdy_bad), 64'd0);
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   logic [DW-1:0] d0, d1, d2, ones, vals, coh, endz, wd;
   int            nw, nr, k, kk;

   initial begin
      app_addr = '0; app_cmd = CMD_WRITE; app_en = 1'b0;
      app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
      d0   = 128'h0123456789ABCDEF_FEDCBA9876543210;
      d1   = {8{16'h1111}};
      d2   = {4{32'hC0FFEE00}};
      ones = {DW{1'b1}};
      vals = {4{32'h5A5A0001}};
      coh  = {4{32'hDEADBEEF}};
      endz = {4{32'h0BADF00D}};
      repeat (2) @(negedge clk);

      do_reset("init");

      // Single write then read-back.
      issue_cmd(CMD_WRITE, 28'h100, '0, "t1_wcmd");
      send_wdf({16{8'hA5}}, '0, 1'b1, "t1_wdf");
      issue_cmd(CMD_READ, 28'h100, {16{8'hA5}}, "t1_rd");
      drain("t1");

      // Data arrives before its commands; back-to-back reads stay in order.
      send_wdf(d0, '0, 1'b1, "t2_wdf0");
      send_wdf(d1, '0, 1'b1, "t2_wdf1");
      send_wdf(d2, '0, 1'b1, "t2_wdf2");
      issue_cmd(CMD_WRITE, 28'h000, '0, "t2_w0");
      issue_cmd(CMD_WRITE, 28'h008, '0, "t2_w1");
      issue_cmd(CMD_WRITE, 28'h010, '0, "t2_w2");
      issue_cmd(CMD_READ, 28'h000, d0, "t2_r0");
      issue_cmd(CMD_READ, 28'h008, d1, "t2_r1");
      issue_cmd(CMD_READ, 28'h010, d2, "t2_r2");
      drain("t2");

      // Byte mask: low 8 bytes masked keep 0xFF, upper 8 bytes take zero.
      issue_cmd(CMD_WRITE, 28'h200, '0, "t3_w_ones");
      send_wdf(ones, '0, 1'b1, "t3_wdf_ones");
      issue_cmd(CMD_WRITE, 28'h200, '0, "t3_w_mask");
      send_wdf('0, 16'h00FF, 1'b1, "t3_wdf_mask");
      issue_cmd(CMD_READ, 28'h200, 128'h0000000000000000_FFFFFFFFFFFFFFFF, "t3_rd");
      drain("t3");

      // Aliasing: 0x2008 and 0x00F both map to beat 1.
      issue_cmd(CMD_WRITE, 28'h2008, '0, "alias_w");
      send_wdf(vals, '0, 1'b1, "alias_wdf");
      issue_cmd(CMD_READ, 28'h00F, vals, "alias_rd");
      drain("alias");

      // Read while write data is still missing must stall, then see the new data.
      issue_cmd(CMD_WRITE, 28'h300, '0, "coh_w");
      fork
         issue_cmd(CMD_READ, 28'h300, coh, "coh_rd");
         begin
            repeat (4) begin
               @(negedge clk);
               #2;
               check("coh_rdy_stall", 64'(app_rdy), 64'd0);
            end
            send_wdf(coh, '0, 1'b1, "coh_wdf");
         end
      join
      drain("coh");

      // Illegal command: accepted, raises err_flag, counters unchanged (8 writes, 7 reads so far).
      check("err_before_illegal", 64'(err_flag), 64'd0);
      issue_cmd(3'b011, 28'h040, '0, "illegal");
      #1;
      check("err_after_illegal", 64'(err_flag), 64'd1);
      check("wr_cnt_after_illegal", 64'(wr_cmd_cnt), 64'd8);
      check("rd_cnt_after_illegal", 64'(rd_cmd_cnt), 64'd7);
      @(negedge clk);

      // Random mix of 64 writes and 64 reads over beats 512..527.
      do_reset("recal");
      for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
      nw = 0;
      nr = 0;
      for (int i = 0; i < 128; i++) begin
         if (nr == 64 || (nw < 64 && (nw == 0 || $urandom_range(0, 1) == 1))) begin
            k  = $urandom_range(0, 15);
            wd = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) begin
               issue_cmd(CMD_WRITE, 28'((512 + k) * 8), '0, "burst_w");
               send_wdf(wd, '0, 1'b1, "burst_wdf");
            end else begin
               send_wdf(wd, '0, 1'b1, "burst_wdf");
               issue_cmd(CMD_WRITE, 28'((512 + k) * 8), '0, "burst_w");
            end
            ref_mem[k] = wd;
            ref_vld[k] = 1'b1;
            nw++;
         end else begin
            k = $urandom_range(0, 15);
            while (!ref_vld[k]) k = (k + 1) % 16;
            issue_cmd(CMD_READ, 28'((512 + k) * 8), ref_mem[k], "burst_r");
            nr++;
         end
      end
      drain("burst");
      check("burst_wr_cnt", 64'(wr_cmd_cnt), 64'd64);
      check("burst_rd_cnt", 64'(rd_cmd_cnt), 64'd64);
      check("burst_err", 64'(err_flag), 64'd0);

      // Reset with reads in flight: remaining pulses dropped, stored data survives.
      kk = 0;
      while (!ref_vld[kk]) kk++;
      repeat (4) issue_cmd(CMD_READ, 28'((512 + kk) * 8), ref_mem[kk], "flight_rd");
      do_reset("flight");
      check("flight_err", 64'(err_flag), 64'd0);
      issue_cmd(CMD_READ, 28'h100, {16{8'hA5}}, "post_rst_rd0");
      issue_cmd(CMD_READ, 28'((512 + kk) * 8), ref_mem[kk], "post_rst_rd1");
      drain("post_rst");

      // Beat without wdf_end is still stored but flags an error.
      send_wdf(endz, '0, 1'b0, "noend_wdf");
      issue_cmd(CMD_WRITE, 28'h12C0, '0, "noend_w");
      check("noend_err", 64'(err_flag), 64'd1);
      issue_cmd(CMD_READ, 28'h12C0, endz, "noend_rd");
      drain("noend");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop if the run ever wedges.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
